ecc_dec_stream: RTL and testbench

- Multi-lane, pipelined extended-Hamming (SECDED) decoder with a valid/ready streaming interface.
- Sits on memory read paths, between the RAM macro and the consumer.
- Adds features the single-word decoder lacks: backpressure, LANES independent code words per beat, saturating single/double error counters, and a first-error capture register for scrub/logging software.

---
 rtl/ecc_pkg.sv | 69 ++++++
 rtl/ecc_dec_lane.sv | 52 +++++
 rtl/ecc_dec_stream.sv | 230 +++++++++++++++++++++++
 tb/tb_ecc_dec_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and helper functions for the streaming SECDED decoder.
// Code-word helpers work on a max-width vector; callers pad and slice.
package ecc_pkg;

    localparam int MAX_N = 63;
    localparam int MAX_M = 8;
    localparam int MAX_K = 64;
    localparam int IW    = 6;

    typedef struct packed {
        logic sb;
        logic db;
        logic fix;
    } lane_flags_t;

    function automatic int calculate_m(input int k);
        int m_v;
        m_v = 0;
        for (int i = MAX_M; i >= 1; i--) begin
            m_v = ((1 << i) >= (i + k + 1)) ? i : m_v;
        end
        return m_v;
    endfunction

    function automatic logic is_power_of_2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Bit i of the syndrome collects every position whose index has bit i set.
    function automatic logic [MAX_M-1:0] calc_syndrome(input logic [MAX_N:0] c);
        logic [MAX_M-1:0] s;
        s = '0;
        for (int j = 1; j <= MAX_N; j++) begin
            for (int i = 0; i < MAX_M; i++) begin
                s[3'(i)] = s[3'(i)] ^ (c[IW'(j)] & (((j >> i) & 1) == 1));
            end
        end
        return s;
    endfunction

    function automatic logic [MAX_N:0] correct_word(input logic [MAX_N:0] c,
                                                    input logic [MAX_M-1:0] syn,
                                                    input logic par,
                                                    input int n);
        logic [MAX_N:0] r;
        r = c;
        for (int j = 1; j <= MAX_N; j++) begin
            r[IW'(j)] = c[IW'(j)] ^ (par && (int'(syn) == j) && (j <= n));
        end
        return r;
    endfunction

    function automatic logic [MAX_K-1:0] extract_data(input logic [MAX_N:0] c, input int k);
        logic [MAX_K-1:0] q;
        int idx;
        q   = '0;
        idx = 0;
        for (int j = 1; j <= MAX_N; j++) begin
            if (!is_power_of_2(j) && (idx < k)) begin
                q[IW'(idx)] = c[IW'(j)];
                idx = idx + 1;
            end else begin
                idx = idx;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/ecc_dec_lane.sv
// Single-lane combinational SECDED datapath: the compute half (reorder, syndrome,
// parity) and the correct half (flip, extract, flags) are independent port groups.
module ecc_dec_lane
    import ecc_pkg::*;
#(
    parameter int K      = 8,
    parameter bit P0_LSB = 1'b1,
    parameter int M      = calculate_m(K),
    parameter int N      = M + K
) (
    input  logic [N:0]   cw_i,
    output logic [N:0]   c_o,
    output logic [M-1:0] syn_o,
    output logic         par_o,
    input  logic [N:0]   c_i,
    input  logic [M-1:0] syn_i,
    input  logic         par_i,
    output logic [K-1:0] q_o,
    output lane_flags_t  flags_o,
    output logic [M:0]   synfield_o
);

    logic [MAX_N:0] cw_ext_s;
    logic [MAX_N:0] c_in_ext_s;
    logic [MAX_N:0] c_fix_s;

    // Compute half: move p0 to bit 0, then syndrome and overall parity.
    always_comb begin
        cw_ext_s = '0;
        if (P0_LSB) begin
            cw_ext_s[N:0] = cw_i;
        end else begin
            cw_ext_s[N:0] = {cw_i[N-1:0], cw_i[N]};
        end
        c_o   = cw_ext_s[N:0];
        syn_o = M'(calc_syndrome(cw_ext_s));
        par_o = ^cw_i;
    end

    // Correct half: a syndrome beyond n leaves the data untouched.
    always_comb begin
        c_in_ext_s      = '0;
        c_in_ext_s[N:0] = c_i;
        c_fix_s         = correct_word(c_in_ext_s, MAX_M'(syn_i), par_i, N);
        q_o             = K'(extract_data(c_fix_s, K));
        flags_o.sb      = par_i;
        flags_o.db      = ~par_i & (|syn_i);
        flags_o.fix     = par_i & (|syn_i) & ~is_power_of_2(int'(syn_i));
        synfield_o      = P0_LSB ? {syn_i, par_i} : {par_i, syn_i};
    end

endmodule

// File: rtl/ecc_dec_stream.sv
// Multi-lane two-stage SECDED decoder with valid/ready flow control,
// saturating error counters and a first-error capture register.
module ecc_dec_stream
    import ecc_pkg::*;
#(
    parameter int K      = 8,
    parameter int LANES  = 4,
    parameter bit P0_LSB = 1'b1,
    parameter int CNT_W  = 16,
    parameter int M      = calculate_m(K),
    parameter int N      = M + K,
    parameter int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [LANES*(N+1)-1:0]   d_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [LANES*K-1:0]       q_o,
    output logic [LANES*(M+1)-1:0]   syndrome_o,
    output logic [LANES-1:0]         sb_err_o,
    output logic [LANES-1:0]         db_err_o,
    output logic [LANES-1:0]         sb_fix_o,
    input  logic                     cnt_clr_i,
    output logic [CNT_W-1:0]         sb_cnt_o,
    output logic [CNT_W-1:0]         db_cnt_o,
    output logic                     cap_valid_o,
    output logic [LW-1:0]            cap_lane_o,
    output logic [M:0]               cap_syndrome_o,
    output logic                     cap_db_o
);

    localparam int SW = CNT_W + $clog2(LANES + 1);

    logic                          s1_valid_q, s1_valid_d;
    logic [LANES-1:0][N:0]         s1_c_q, s1_c_d, s1_c_s;
    logic [LANES-1:0][M-1:0]       s1_syn_q, s1_syn_d, s1_syn_s;
    logic [LANES-1:0]              s1_par_q, s1_par_d, s1_par_s;
    logic                          s2_valid_q, s2_valid_d;
    logic [LANES*K-1:0]            q_q, q_d, q_s;
    logic [LANES*(M+1)-1:0]        syn_q, syn_d, syn_s;
    logic [LANES-1:0]              sb_q, sb_d, db_q, db_d, fix_q, fix_d;
    lane_flags_t [LANES-1:0]       flags_s;
    logic [CNT_W-1:0]              sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
    logic [SW-1:0]                 sb_sum_s, db_sum_s;
    logic                          cap_valid_q, cap_valid_d;
    logic [LW-1:0]                 cap_lane_q, cap_lane_d, sel_lane_s;
    logic [M:0]                    cap_syn_q, cap_syn_d;
    logic                          cap_db_q, cap_db_d;
    logic [LANES-1:0]              err_s;
    logic                          s1_load_s, s2_load_s, out_hs_s;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [K-1:0]  s1_unused_q_s;
        lane_flags_t   s1_unused_flags_s;
        logic [M:0]    s1_unused_fld_s;
        logic [N:0]    s2_unused_c_s;
        logic [M-1:0]  s2_unused_syn_s;
        logic          s2_unused_par_s;

        ecc_dec_lane #(.K(K), .P0_LSB(P0_LSB), .M(M), .N(N)) u_compute (
            .cw_i       (d_i[l*(N+1) +: N+1]),
            .c_o        (s1_c_s[l]),
            .syn_o      (s1_syn_s[l]),
            .par_o      (s1_par_s[l]),
            .c_i        ('0),
            .syn_i      ('0),
            .par_i      (1'b0),
            .q_o        (s1_unused_q_s),
            .flags_o    (s1_unused_flags_s),
            .synfield_o (s1_unused_fld_s)
        );

        ecc_dec_lane #(.K(K), .P0_LSB(P0_LSB), .M(M), .N(N)) u_correct (
            .cw_i       ('0),
            .c_o        (s2_unused_c_s),
            .syn_o      (s2_unused_syn_s),
            .par_o      (s2_unused_par_s),
            .c_i        (s1_c_q[l]),
            .syn_i      (s1_syn_q[l]),
            .par_i      (s1_par_q[l]),
            .q_o        (q_s[l*K +: K]),
            .flags_o    (flags_s[l]),
            .synfield_o (syn_s[l*(M+1) +: M+1])
        );
    end

    // Handshake: a stage accepts when empty or when its contents move on.
    always_comb begin
        s2_load_s = ~s2_valid_q | ready_i;
        s1_load_s = ~s1_valid_q | s2_load_s;
        out_hs_s  = s2_valid_q & ready_i;
    end

    assign ready_o = s1_load_s;

    // Stage 1 next state.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_c_d     = s1_c_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_load_s) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_c_d   = s1_c_s;
                s1_syn_d = s1_syn_s;
                s1_par_d = s1_par_s;
            end else begin
                s1_c_d   = s1_c_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state; payload only changes when a real beat arrives.
    always_comb begin
        s2_valid_d = s2_valid_q;
        q_d        = q_q;
        syn_d      = syn_q;
        sb_d       = sb_q;
        db_d       = db_q;
        fix_d      = fix_q;
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                q_d   = q_s;
                syn_d = syn_s;
                for (int l = 0; l < LANES; l++) begin
                    sb_d[l]  = flags_s[l].sb;
                    db_d[l]  = flags_s[l].db;
                    fix_d[l] = flags_s[l].fix;
                end
            end else begin
                q_d = q_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Counters: clear wins over history, the beat's increment still lands.
    always_comb begin
        sb_sum_s = cnt_clr_i ? '0 : SW'(sb_cnt_q);
        db_sum_s = cnt_clr_i ? '0 : SW'(db_cnt_q);
        for (int l = 0; l < LANES; l++) begin
            sb_sum_s = sb_sum_s + SW'(sb_q[l] & out_hs_s);
            db_sum_s = db_sum_s + SW'(db_q[l] & out_hs_s);
        end
        sb_cnt_d = (sb_sum_s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sb_sum_s);
        db_cnt_d = (db_sum_s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(db_sum_s);
    end

    // Capture register: first erroring lane of the first erroring beat.
    always_comb begin
        err_s      = sb_q | db_q;
        sel_lane_s = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            sel_lane_s = err_s[l] ? LW'(l) : sel_lane_s;
        end
        cap_valid_d = cnt_clr_i ? 1'b0 : cap_valid_q;
        cap_lane_d  = cnt_clr_i ? '0   : cap_lane_q;
        cap_syn_d   = cnt_clr_i ? '0   : cap_syn_q;
        cap_db_d    = cnt_clr_i ? 1'b0 : cap_db_q;
        if (out_hs_s && !cap_valid_d && (|err_s)) begin
            cap_valid_d = 1'b1;
            cap_lane_d  = sel_lane_s;
            cap_syn_d   = syn_q[sel_lane_s*(M+1) +: M+1];
            cap_db_d    = db_q[sel_lane_s];
        end else begin
            cap_valid_d = cap_valid_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_c_q      <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= '0;
            s2_valid_q  <= 1'b0;
            q_q         <= '0;
            syn_q       <= '0;
            sb_q        <= '0;
            db_q        <= '0;
            fix_q       <= '0;
            sb_cnt_q    <= '0;
            db_cnt_q    <= '0;
            cap_valid_q <= 1'b0;
            cap_lane_q  <= '0;
            cap_syn_q   <= '0;
            cap_db_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_c_q      <= s1_c_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s2_valid_q  <= s2_valid_d;
            q_q         <= q_d;
            syn_q       <= syn_d;
            sb_q        <= sb_d;
            db_q        <= db_d;
            fix_q       <= fix_d;
            sb_cnt_q    <= sb_cnt_d;
            db_cnt_q    <= db_cnt_d;
            cap_valid_q <= cap_valid_d;
            cap_lane_q  <= cap_lane_d;
            cap_syn_q   <= cap_syn_d;
            cap_db_q    <= cap_db_d;
        end
    end

    assign valid_o        = s2_valid_q;
    assign q_o            = q_q;
    assign syndrome_o     = syn_q;
    assign sb_err_o       = sb_q;
    assign db_err_o       = db_q;
    assign sb_fix_o       = fix_q;
    assign sb_cnt_o       = sb_cnt_q;
    assign db_cnt_o       = db_cnt_q;
    assign cap_valid_o    = cap_valid_q;
    assign cap_lane_o     = cap_lane_q;
    assign cap_syndrome_o = cap_syn_q;
    assign cap_db_o       = cap_db_q;

endmodule

// File: tb/tb_ecc_dec_stream.sv
// Randomized bench for ecc_dec_stream against a positional-XOR SECDED model
// and a queue-based occupancy model (two slots, head visible at age >= 2).
module tb_ecc_dec_stream;

    localparam int KB = 8;
    localparam int NL = 4;
    localparam int CW = 13;
    localparam int DW = NL * CW;
    localparam int SMAX = 15;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [DW-1:0]   d_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [NL*KB-1:0] q_o;
    logic [NL*5-1:0] syndrome_o;
    logic [NL-1:0]   sb_err_o, db_err_o, sb_fix_o;
    logic            cnt_clr_i = 1'b0;
    logic [3:0]      sb_cnt_o, db_cnt_o;
    logic            cap_valid_o;
    logic [1:0]      cap_lane_o;
    logic [4:0]      cap_syndrome_o;
    logic            cap_db_o;

    ecc_dec_stream #(.K(KB), .LANES(NL), .P0_LSB(1'b1), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .d_i(d_i),
        .valid_o(valid_o), .ready_i(ready_i), .q_o(q_o), .syndrome_o(syndrome_o),
        .sb_err_o(sb_err_o), .db_err_o(db_err_o), .sb_fix_o(sb_fix_o), .cnt_clr_i(cnt_clr_i),
        .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o), .cap_valid_o(cap_valid_o),
        .cap_lane_o(cap_lane_o), .cap_syndrome_o(cap_syndrome_o), .cap_db_o(cap_db_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] mq[$];
    int age_q[$];
    int m_sb, m_db, m_cap_lane, m_cap_db;
    logic m_cap_v;
    logic [4:0] m_cap_syn;
    int acc;
    logic [NL*KB-1:0] last_q;
    logic [NL*5-1:0] last_syn;
    logic [NL-1:0] last_sb, last_db, last_fix;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Overall parity is popcount parity; syndrome is the XOR of set-bit positions.
    function automatic void ref_lane(input logic [12:0] cw, output logic [7:0] q, output logic [4:0] fld,
                                     output logic sb, output logic db, output logic fix);
        logic [12:0] c;
        int syn, par;
        c = cw; syn = 0; par = 0;
        for (int j = 0; j < CW; j++) begin
            if (c[j]) begin par = par ^ 1; syn = syn ^ j; end
        end
        sb  = (par == 1);
        db  = (par == 0) && (syn != 0);
        fix = (par == 1) && (syn != 0) && ((syn & (syn - 1)) != 0);
        if (par == 1 && syn >= 1 && syn <= 12) c[syn] = ~c[syn];
        q   = {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
        fld = {4'(syn), 1'(par)};
    endfunction

    function automatic void ref_beat(input logic [DW-1:0] d, output logic [NL*KB-1:0] q,
                                     output logic [NL*5-1:0] syn, output logic [NL-1:0] sb,
                                     output logic [NL-1:0] db, output logic [NL-1:0] fix);
        logic [7:0] lq; logic [4:0] lf; logic ls, ld, lx;
        for (int l = 0; l < NL; l++) begin
            ref_lane(d[l*CW +: CW], lq, lf, ls, ld, lx);
            q[l*KB +: KB] = lq; syn[l*5 +: 5] = lf; sb[l] = ls; db[l] = ld; fix[l] = lx;
        end
    endfunction

    function automatic logic [12:0] encode(input logic [7:0] data);
        int pos [8];
        logic [12:0] c;
        int syn;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12};
        c = '0; syn = 0;
        for (int i = 0; i < KB; i++) begin
            c[pos[i]] = data[i];
            if (data[i]) syn = syn ^ pos[i];
        end
        for (int b = 0; b < 4; b++) if (((syn >> b) & 1) == 1) c[1 << b] = 1'b1;
        c[0] = ^c[12:1];
        return c;
    endfunction

    function automatic logic [12:0] rand_word();
        logic [12:0] c;
        int a, b;
        c = encode(8'($urandom));
        case ($urandom_range(0, 3))
            1: begin a = $urandom_range(0, 12); c[a] = ~c[a]; end
            2: begin
                a = $urandom_range(0, 12); b = (a + $urandom_range(1, 12)) % CW;
                c[a] = ~c[a]; c[b] = ~c[b];
            end
            3: c = 13'($urandom);
            default: c = c;
        endcase
        return c;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        return {rand_word(), rand_word(), rand_word(), rand_word()};
    endfunction

    task automatic model_clear();
        m_sb = 0; m_db = 0; m_cap_v = 1'b0; m_cap_lane = 0; m_cap_syn = '0; m_cap_db = 0;
    endtask

    // One clock: drive, compare against the model, then advance the model past the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        logic exp_valid, exp_ready, in_hs, out_hs;
        logic [NL*KB-1:0] eq; logic [NL*5-1:0] es; logic [NL-1:0] eb, ed, ef;
        logic [DW-1:0] hd;
        @(negedge clk);
        valid_i = v; d_i = d; ready_i = rdy; cnt_clr_i = clr;
        #1;
        exp_valid = (mq.size() > 0) && (age_q[0] >= 2);
        exp_ready = !(mq.size() == 2 && !rdy);
        check("valid_o", 64'(valid_o), 64'(exp_valid));
        check("ready_o", 64'(ready_o), 64'(exp_ready));
        check("sb_cnt", 64'(sb_cnt_o), 64'(m_sb));
        check("db_cnt", 64'(db_cnt_o), 64'(m_db));
        check("cap_valid", 64'(cap_valid_o), 64'(m_cap_v));
        if (m_cap_v) begin
            check("cap_lane", 64'(cap_lane_o), 64'(m_cap_lane));
            check("cap_syn", 64'(cap_syndrome_o), 64'(m_cap_syn));
            check("cap_db", 64'(cap_db_o), 64'(m_cap_db));
        end
        if (exp_valid) begin
            ref_beat(mq[0], eq, es, eb, ed, ef);
            check("q_o", 64'(q_o), 64'(eq));
            check("syndrome_o", 64'(syndrome_o), 64'(es));
            check("sb_err", 64'(sb_err_o), 64'(eb));
            check("db_err", 64'(db_err_o), 64'(ed));
            check("sb_fix", 64'(sb_fix_o), 64'(ef));
        end
        in_hs  = v & exp_ready;
        out_hs = exp_valid & rdy;
        if (out_hs) begin
            last_q = q_o; last_syn = syndrome_o; last_sb = sb_err_o; last_db = db_err_o; last_fix = sb_fix_o;
        end
        @(posedge clk);
        if (clr) model_clear();
        if (out_hs) begin
            hd = mq.pop_front();
            void'(age_q.pop_front());
            ref_beat(hd, eq, es, eb, ed, ef);
            m_sb = (m_sb + $countones(eb) > SMAX) ? SMAX : m_sb + $countones(eb);
            m_db = (m_db + $countones(ed) > SMAX) ? SMAX : m_db + $countones(ed);
            if (!m_cap_v) begin
                for (int l = NL - 1; l >= 0; l--) begin
                    if (eb[l] || ed[l]) begin
                        m_cap_lane = l; m_cap_syn = es[l*5 +: 5]; m_cap_db = ed[l];
                    end
                end
                m_cap_v = |(eb | ed);
            end
        end
        if (in_hs) begin
            mq.push_back(d); age_q.push_back(0); acc++;
        end
        foreach (age_q[i]) age_q[i] = age_q[i] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; cnt_clr_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check("rst_sb_cnt", 64'(sb_cnt_o), 64'd0);
        check("rst_db_cnt", 64'(db_cnt_o), 64'd0);
        check("rst_cap_valid", 64'(cap_valid_o), 64'd0);
        check("rst_q_o", 64'(q_o), 64'd0);
        check("rst_flags", 64'({sb_err_o, db_err_o, sb_fix_o}), 64'd0);
        check("rst_syndrome", 64'(syndrome_o), 64'd0);
        mq.delete(); age_q.delete(); model_clear();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] w;
        model_clear();
        acc = 0;
        do_reset();

        // All-zero beat: 2-cycle latency, clean flags.
        cycle(1'b1, '0, 1'b1, 1'b0);
        idle(3);
        check("zero_q", 64'(last_q), 64'd0);
        check("zero_flags", 64'({last_sb, last_db, last_fix}), 64'd0);

        // Single error at position 3 in lane 2.
        w = '0; w[2*CW +: CW] = 13'h0008;
        cycle(1'b1, w, 1'b1, 1'b0);
        idle(3);
        check("sb_lane2_syn", 64'(last_syn[2*5 +: 5]), 64'(5'b00111));
        check("sb_lane2_flags", 64'({last_sb, last_fix}), 64'({4'b0100, 4'b0100}));
        check("sb_lane2_q", 64'(last_q), 64'd0);
        check("sb_cnt_one", 64'(sb_cnt_o), 64'd1);
        check("cap_lane2", 64'({cap_valid_o, cap_lane_o, cap_syndrome_o, cap_db_o}),
              64'({1'b1, 2'd2, 5'b00111, 1'b0}));

        // Double error in lane 0 plus p0-only error in lane 1, after a clear.
        cycle(1'b0, '0, 1'b1, 1'b1);
        w = '0; w[0 +: CW] = 13'h0028; w[CW +: CW] = 13'h0001;
        cycle(1'b1, w, 1'b1, 1'b0);
        idle(3);
        check("db_lane0_syn", 64'(last_syn[4:0]), 64'(5'b01100));
        check("db_flags", 64'({last_sb, last_db, last_fix}), 64'({4'b0010, 4'b0001, 4'b0000}));
        check("db_cnt_one", 64'(db_cnt_o), 64'd1);
        check("cap_lane0_db", 64'({cap_lane_o, cap_syndrome_o, cap_db_o}), 64'({2'd0, 5'b01100, 1'b1}));

        // Saturation, then clear coincident with an output handshake.
        w = '0; w[3*CW +: CW] = 13'h0008;
        for (int i = 0; i < 20; i++) cycle(1'b1, w, 1'b1, 1'b0);
        idle(3);
        check("sb_cnt_sat", 64'(sb_cnt_o), 64'd15);
        cycle(1'b1, w, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle(1);
        check("clr_hs_cnt", 64'(sb_cnt_o), 64'd1);
        check("clr_hs_cap", 64'({cap_valid_o, cap_lane_o}), 64'({1'b1, 2'd3}));

        // Backpressure with ready pattern 1,0,0,1.
        acc = 0;
        for (int i = 0; i < 100 && acc < 8; i++) cycle(1'b1, rand_beat(), (i % 4 == 0) || (i % 4 == 3), 1'b0);
        check("stall_accepts", 64'(acc), 64'd8);
        for (int i = 0; i < 12 && mq.size() > 0; i++) cycle(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        check("stall_drain", 64'(mq.size()), 64'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        for (int i = 0; i < 10 && mq.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("rand_drain", 64'(mq.size()), 64'd0);

        // Reset with two beats in flight: they must never emerge.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b0);
        check("inflight_two", 64'(mq.size()), 64'd2);
        do_reset();
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
